// File: rtl/dynamixel_pkg.sv
// Shared Dynamixel 2.0 protocol constants, packet FSM states and the CRC-16 byte update
// used by the sync-write generator (and later by read/status parsers).
package dynamixel_pkg;

    localparam logic [7:0] HDR_FF           = 8'hFF;
    localparam logic [7:0] HDR_FD           = 8'hFD;
    localparam logic [7:0] RESERVED         = 8'h00;
    localparam logic [7:0] BROADCAST_ID     = 8'hFE;
    localparam logic [7:0] INSTR_SYNC_WRITE = 8'h83;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_HDR1,
        ST_HDR2,
        ST_RSV,
        ST_PID,
        ST_LEN_L,
        ST_LEN_H,
        ST_INSTR,
        ST_ADDR_L,
        ST_ADDR_H,
        ST_DLEN_L,
        ST_DLEN_H,
        ST_DEV_ID,
        ST_DEV_DATA,
        ST_CRC_L,
        ST_CRC_H,
        ST_DRAIN
    } sw_state_t;

    // Non-reflected CRC-16, polynomial 0x8005, MSB first.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/dynamixel_sync_write_uart.sv
// 8N1 UART transmitter: one-cycle send accepted only when idle, one-cycle done pulse
// after the stop bit, pin idles high.
module uart #(
    parameter int clocks_per_bit = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] byte_to_send,
    output logic       done,
    output logic       pin
);

    localparam int CW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;

    logic          busy;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bits_left;
    logic [8:0]    shift;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pin       <= 1'b1;
            clk_cnt   <= '0;
            bits_left <= '0;
            shift     <= '1;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (send) begin
                    busy      <= 1'b1;
                    pin       <= 1'b0;
                    shift     <= {1'b1, byte_to_send};
                    bits_left <= 4'd9;
                    clk_cnt   <= CW'(clocks_per_bit - 1);
                end
            end else if (clk_cnt != '0) begin
                clk_cnt <= clk_cnt - 1'b1;
            end else if (bits_left == 4'd0) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                // Data bits LSB first, then the stop bit shifted in from the top.
                pin       <= shift[0];
                shift     <= {1'b1, shift[8:1]};
                bits_left <= bits_left - 1'b1;
                clk_cnt   <= CW'(clocks_per_bit - 1);
            end
        end
    end

endmodule

// File: rtl/dynamixel_sync_write.sv
// Dynamixel 2.0 Sync Write (0x83) packet generator on one UART TX pin.
// Optional macro DYNAMIXEL_TX_ENABLE_EN adds a half-duplex direction output tx_en.
//
// state       | meaning
// ST_IDLE     | ready; start issues HDR0 (FF)
// ST_HDR1..   | waiting for the previous byte's uart done, then issue the named field
// ST_DEV_ID   | issue id of device dev_idx
// ST_DEV_DATA | issue data byte byte_idx of device dev_idx
// ST_CRC_L/H  | issue CRC low / high byte (not folded into the CRC)
// ST_DRAIN    | wait for CRC_H stop bit, then pulse done
module dynamixel_sync_write
    import dynamixel_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 1,
    parameter int NUM_DEVICES    = 4,
    parameter int DATA_BYTES     = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [8*NUM_DEVICES-1:0]            ids,
    input  logic [15:0]                         address,
    input  logic [8*DATA_BYTES*NUM_DEVICES-1:0] values,
    output logic                                ready,
    output logic                                done,
    output logic                                pin
`ifdef DYNAMIXEL_TX_ENABLE_EN
    ,
    output logic                                tx_en
`endif
);

    localparam int          DW  = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
    localparam int          BW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [15:0] LEN = 16'(7 + NUM_DEVICES * (1 + DATA_BYTES));

    sw_state_t                          state, state_nx;
    logic [8*NUM_DEVICES-1:0]           ids_q;
    logic [15:0]                        address_q;
    logic [8*DATA_BYTES*NUM_DEVICES-1:0] values_q;
    logic [15:0]                        crc;
    logic [DW-1:0]                      dev_idx;
    logic [BW-1:0]                      byte_idx;
    logic                               uart_done, send, fire, fold, finish;
    logic                               last_byte, last_dev;
    logic [7:0]                         tx_byte;

    assign ready     = (state == ST_IDLE);
    assign last_byte = (byte_idx == BW'(DATA_BYTES - 1));
    assign last_dev  = (dev_idx == DW'(NUM_DEVICES - 1));

    always_comb begin
        state_nx = state;
        tx_byte  = 8'h00;
        unique case (state)
            ST_IDLE:     begin tx_byte = HDR_FF;           state_nx = ST_HDR1;   end
            ST_HDR1:     begin tx_byte = HDR_FF;           state_nx = ST_HDR2;   end
            ST_HDR2:     begin tx_byte = HDR_FD;           state_nx = ST_RSV;    end
            ST_RSV:      begin tx_byte = RESERVED;         state_nx = ST_PID;    end
            ST_PID:      begin tx_byte = BROADCAST_ID;     state_nx = ST_LEN_L;  end
            ST_LEN_L:    begin tx_byte = LEN[7:0];         state_nx = ST_LEN_H;  end
            ST_LEN_H:    begin tx_byte = LEN[15:8];        state_nx = ST_INSTR;  end
            ST_INSTR:    begin tx_byte = INSTR_SYNC_WRITE; state_nx = ST_ADDR_L; end
            ST_ADDR_L:   begin tx_byte = address_q[7:0];   state_nx = ST_ADDR_H; end
            ST_ADDR_H:   begin tx_byte = address_q[15:8];  state_nx = ST_DLEN_L; end
            ST_DLEN_L:   begin tx_byte = 8'(DATA_BYTES);   state_nx = ST_DLEN_H; end
            ST_DLEN_H:   begin tx_byte = 8'h00;            state_nx = ST_DEV_ID; end
            ST_DEV_ID: begin
                tx_byte  = ids_q[8*int'(dev_idx) +: 8];
                state_nx = ST_DEV_DATA;
            end
            ST_DEV_DATA: begin
                tx_byte = values_q[8*(DATA_BYTES*int'(dev_idx) + int'(byte_idx)) +: 8];
                if (last_byte && last_dev) state_nx = ST_CRC_L;
                else if (last_byte)        state_nx = ST_DEV_ID;
                else                       state_nx = ST_DEV_DATA;
            end
            ST_CRC_L:    begin tx_byte = crc[7:0];         state_nx = ST_CRC_H;  end
            ST_CRC_H:    begin tx_byte = crc[15:8];        state_nx = ST_DRAIN;  end
            ST_DRAIN:    begin                             state_nx = ST_IDLE;   end
            default:     begin                             state_nx = ST_IDLE;   end
        endcase

        // Every non-idle state advances only on the uart done of the previous byte.
        fire = (state == ST_IDLE) ? start : uart_done;
        if (!fire) state_nx = state;
        send   = fire && (state != ST_DRAIN);
        fold   = send && (state != ST_CRC_L) && (state != ST_CRC_H);
        finish = fire && (state == ST_DRAIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            crc       <= '0;
            dev_idx   <= '0;
            byte_idx  <= '0;
            done      <= 1'b0;
            ids_q     <= '0;
            address_q <= '0;
            values_q  <= '0;
        end else begin
            state <= state_nx;
            done  <= finish;
            if (state == ST_IDLE && start) begin
                ids_q     <= ids;
                address_q <= address;
                values_q  <= values;
                dev_idx   <= '0;
                byte_idx  <= '0;
            end
            if (fold) crc <= crc16_update((state == ST_IDLE) ? 16'h0000 : crc, tx_byte);
            if (fire && state == ST_DEV_DATA) begin
                if (last_byte) begin
                    byte_idx <= '0;
                    dev_idx  <= last_dev ? '0 : dev_idx + 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

`ifdef DYNAMIXEL_TX_ENABLE_EN
    always_ff @(posedge clock) begin
        if (reset)                          tx_en <= 1'b0;
        else if (state == ST_IDLE && start) tx_en <= 1'b1;
        else if (finish)                    tx_en <= 1'b0;
    end
`endif

    uart #(
        .clocks_per_bit(CLOCKS_PER_BIT)
    ) u_uart (
        .clock       (clock),
        .reset       (reset),
        .send        (send),
        .byte_to_send(tx_byte),
        .done        (uart_done),
        .pin         (pin)
    );

endmodule

// File: tb/tb_dynamixel_sync_write.sv
// Directed bench for dynamixel_sync_write: three instances (2x4, 1x1, 4x4) with the
// pin decoded back into bytes and compared against hand-built packets.
module tb_dynamixel_sync_write;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // manual example instance: 2 devices x 4 bytes, 4 clocks per bit
    logic         start_m = 1'b0;
    logic [15:0]  ids_m = '0;
    logic [15:0]  address_m = '0;
    logic [63:0]  values_m = '0;
    logic         ready_m, done_m, pin_m;
    // edge instance: 1 device x 1 byte, 2 clocks per bit
    logic         start_e = 1'b0;
    logic [7:0]   ids_e = '0;
    logic [15:0]  address_e = '0;
    logic [7:0]   values_e = '0;
    logic         ready_e, done_e, pin_e;
    // default instance: 4 devices x 4 bytes, 1 clock per bit
    logic         start_d = 1'b0;
    logic [31:0]  ids_d = '0;
    logic [15:0]  address_d = '0;
    logic [127:0] values_d = '0;
    logic         ready_d, done_d, pin_d;
`ifdef DYNAMIXEL_TX_ENABLE_EN
    logic         tx_en_m, tx_en_e, tx_en_d, obs_tx_en;
`endif

    dynamixel_sync_write #(.CLOCKS_PER_BIT(4), .NUM_DEVICES(2), .DATA_BYTES(4)) u_man (
        .clock(clock), .reset(reset), .start(start_m), .ids(ids_m), .address(address_m),
        .values(values_m), .ready(ready_m), .done(done_m), .pin(pin_m)
`ifdef DYNAMIXEL_TX_ENABLE_EN
        , .tx_en(tx_en_m)
`endif
    );

    dynamixel_sync_write #(.CLOCKS_PER_BIT(2), .NUM_DEVICES(1), .DATA_BYTES(1)) u_edge (
        .clock(clock), .reset(reset), .start(start_e), .ids(ids_e), .address(address_e),
        .values(values_e), .ready(ready_e), .done(done_e), .pin(pin_e)
`ifdef DYNAMIXEL_TX_ENABLE_EN
        , .tx_en(tx_en_e)
`endif
    );

    dynamixel_sync_write #(.CLOCKS_PER_BIT(1)) u_def (
        .clock(clock), .reset(reset), .start(start_d), .ids(ids_d), .address(address_d),
        .values(values_d), .ready(ready_d), .done(done_d), .pin(pin_d)
`ifdef DYNAMIXEL_TX_ENABLE_EN
        , .tx_en(tx_en_d)
`endif
    );

    int   sel = 0;
    logic obs_pin, obs_done, obs_ready;
    always_comb begin
        obs_pin = pin_m; obs_done = done_m; obs_ready = ready_m;
`ifdef DYNAMIXEL_TX_ENABLE_EN
        obs_tx_en = tx_en_m;
`endif
        if (sel == 1) begin
            obs_pin = pin_e; obs_done = done_e; obs_ready = ready_e;
`ifdef DYNAMIXEL_TX_ENABLE_EN
            obs_tx_en = tx_en_e;
`endif
        end else if (sel == 2) begin
            obs_pin = pin_d; obs_done = done_d; obs_ready = ready_d;
`ifdef DYNAMIXEL_TX_ENABLE_EN
            obs_tx_en = tx_en_d;
`endif
        end
    end

    int dcnt [3] = '{0, 0, 0};
    always @(negedge clock) begin
        if (done_m === 1'b1) dcnt[0]++;
        if (done_e === 1'b1) dcnt[1]++;
        if (done_d === 1'b1) dcnt[2]++;
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] rx [64];
    logic [7:0] exp_b [64];
    int         exp_n;
    logic [7:0] man_exp [24] = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'hFE, 8'h11, 8'h00, 8'h83,
                                 8'h74, 8'h00, 8'h04, 8'h00, 8'h01, 8'h96, 8'h00, 8'h00,
                                 8'h00, 8'h02, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h82, 8'h87};

    // Bit-serial reference CRC over exp_b[0..n-1].
    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] c = 16'h0000;
        logic        fb;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ exp_b[i][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    task automatic build_exp(input int nd, input int db, input logic [127:0] idv,
                             input logic [15:0] addr, input logic [511:0] vals);
        int          n;
        logic [15:0] len, c;
        len = 16'(7 + nd * (1 + db));
        exp_b[0] = 8'hFF; exp_b[1] = 8'hFF; exp_b[2] = 8'hFD; exp_b[3] = 8'h00;
        exp_b[4] = 8'hFE; exp_b[5] = len[7:0]; exp_b[6] = len[15:8]; exp_b[7] = 8'h83;
        exp_b[8] = addr[7:0]; exp_b[9] = addr[15:8]; exp_b[10] = 8'(db); exp_b[11] = 8'h00;
        n = 12;
        for (int d = 0; d < nd; d++) begin
            exp_b[n] = idv[8*d +: 8];
            n++;
            for (int b = 0; b < db; b++) begin
                exp_b[n] = vals[8*(db*d + b) +: 8];
                n++;
            end
        end
        c = ref_crc(n);
        exp_b[n] = c[7:0];
        exp_b[n+1] = c[15:8];
        exp_n = n + 2;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        if (sel == 0) start_m = 1'b1;
        else if (sel == 1) start_e = 1'b1;
        else start_d = 1'b1;
        @(posedge clock);
        #1;
        start_m = 1'b0; start_e = 1'b0; start_d = 1'b0;
        chk("ready_low_after_accept", obs_ready, 1'b0);
`ifdef DYNAMIXEL_TX_ENABLE_EN
        chk("tx_en_high_after_accept", obs_tx_en, 1'b1);
`endif
    endtask

    task automatic capture(input int n, input int cpb);
        bit         got;
        logic [7:0] b;
        for (int k = 0; k < 64; k++) rx[k] = 8'hxx;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge clock);
                if (obs_pin === 1'b0) got = 1'b1;
            end
            if (!got) begin
                chk("rx_start_bit", obs_pin, 1'b0);
                return;
            end
            for (int i = 0; i < 8; i++) begin
                repeat (cpb) @(negedge clock);
                b[i] = obs_pin;
            end
            repeat (cpb) @(negedge clock);
            if (obs_pin !== 1'b1) chk("rx_stop_bit", obs_pin, 1'b1);
            rx[k] = b;
        end
    endtask

    task automatic check_pkt(input string tag);
        for (int k = 0; k < exp_n; k++) chk($sformatf("%s_byte%0d", tag, k), rx[k], exp_b[k]);
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
`ifdef DYNAMIXEL_TX_ENABLE_EN
        chk({tag, "_tx_en_in_drain"}, obs_tx_en, 1'b1);
`endif
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clock);
            if (obs_done === 1'b1) got = 1'b1;
        end
        chk({tag, "_done_pulse"}, obs_done, 1'b1);
        if (got) begin
            chk({tag, "_ready_with_done"}, obs_ready, 1'b1);
`ifdef DYNAMIXEL_TX_ENABLE_EN
            chk({tag, "_tx_en_falls"}, obs_tx_en, 1'b0);
`endif
            @(negedge clock);
            chk({tag, "_done_one_cycle"}, obs_done, 1'b0);
        end
    endtask

    int lows;

    initial begin
        // reset state
        repeat (3) @(negedge clock);
        chk("rst_ready_m", ready_m, 1'b1);
        chk("rst_ready_d", ready_d, 1'b1);
        chk("rst_done_m", done_m, 1'b0);
        chk("rst_pin_m", pin_m, 1'b1);
        chk("rst_pin_e", pin_e, 1'b1);
`ifdef DYNAMIXEL_TX_ENABLE_EN
        chk("rst_tx_en_m", tx_en_m, 1'b0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // manual example, fixed expected bytes including CRC 0x8782
        sel = 0;
        ids_m = 16'h0201; address_m = 16'h0074; values_m = {32'h000000AA, 32'h00000096};
        pulse_start();
        capture(24, 4);
        for (int k = 0; k < 24; k++) chk($sformatf("man_byte%0d", k), rx[k], man_exp[k]);
        wait_done("man");
        repeat (5) @(negedge clock);
        chk("man_done_count", dcnt[0], 1);

        // 1x1 edge case with a busy start and input changes mid-packet
        sel = 1;
        ids_e = 8'h05; address_e = 16'h1234; values_e = 8'h7F;
        build_exp(1, 1, 128'(8'h05), 16'h1234, 512'(8'h7F));
        chk("edge_len_l", exp_b[5], 8'h09);
        pulse_start();
        fork
            capture(16, 2);
            begin
                repeat (40) @(negedge clock);
                start_e = 1'b1; ids_e = 8'hEE; values_e = 8'h11; address_e = 16'hBEEF;
                @(negedge clock);
                start_e = 1'b0;
            end
        join
        check_pkt("edge");
        wait_done("edge");
        lows = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            if (pin_e !== 1'b1) lows++;
        end
        chk("edge_no_second_packet", lows, 0);
        chk("edge_done_count", dcnt[1], 1);

        // defaults 4x4 with random content
        sel = 2;
        ids_d = $urandom;
        values_d = {$urandom, $urandom, $urandom, $urandom};
        address_d = 16'($urandom_range(0, 65535));
        if (address_d == 16'h0074) address_d = 16'h0075;
        build_exp(4, 4, 128'(ids_d), address_d, 512'(values_d));
        chk("def_len_l", exp_b[5], 8'h1B);
        pulse_start();
        capture(34, 1);
        check_pkt("def");
        wait_done("def");
        chk("def_done_count", dcnt[2], 1);

        // reset while the first device's data bytes are on the wire
        pulse_start();
        repeat (148) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_pin_high", pin_d, 1'b1);
        chk("midrst_ready", ready_d, 1'b1);
`ifdef DYNAMIXEL_TX_ENABLE_EN
        chk("midrst_tx_en", tx_en_d, 1'b0);
`endif
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("midrst_no_done", dcnt[2], 1);

        ids_d = 32'h0A0B0C0D;
        values_d = {$urandom, $urandom, $urandom, $urandom};
        address_d = 16'h0102;
        build_exp(4, 4, 128'(ids_d), address_d, 512'(values_d));
        pulse_start();
        capture(34, 1);
        check_pkt("after_rst");
        wait_done("after_rst");
        chk("after_rst_done_count", dcnt[2], 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
